// File: rtl/falco_mem_arbiter.sv
// ----------------------------------------------------------------------------
// falco_mem_arbiter
//
// Purpose:
//   Shares one memory port between the core's three requesters: instruction
//   fetch (IF), load (LD) and store (ST). At most one request is issued per
//   cycle. Reads are remembered in an in-order tag FIFO so that each read
//   response can be sent back to the requester that issued it. Stores are
//   posted, and the store port gets a one-cycle acknowledge pulse on the cycle
//   after the store is accepted.
//
// Parameters:
//   ADDR_W       request address width
//   DATA_W       data width (BE_W = DATA_W/8 byte enables)
//   MAX_OUTST    maximum outstanding reads, which is also the tag FIFO depth
//                (power of 2, >= 2)
//   STARVE_LIMIT number of waiting cycles before a fetch is promoted (1..15)
//
// Ports:
//   clk, rst_n                  clock; asynchronous active-low reset
//   if_req_* / if_resp_*        fetch request (valid/ready/addr) and response
//   ld_req_* / ld_resp_*        load request (valid/ready/addr) and response
//   st_req_* / st_resp_valid    store request (valid/ready/addr/data/be) and ack
//   mem_req_*                   shared memory request (valid/ready/we/addr/
//                               wdata/be)
//   mem_resp_valid/_rdata       in-order read data returned by the memory
//   err_unexp_resp              sticky flag: a response arrived while no read
//                               was outstanding
//
// Configuration macro:
//   FALCO_ARB_STARVE_EN  when defined, a waiting fetch is promoted above LD
//                        and ST once it has waited STARVE_LIMIT cycles. When
//                        undefined there is no starvation counter and the
//                        priority is strictly LD > ST > IF.
// ----------------------------------------------------------------------------
module falco_mem_arbiter #(
  parameter int  ADDR_W       = 32,
  parameter int  DATA_W       = 32,
  parameter int  MAX_OUTST    = 4,
  parameter int  STARVE_LIMIT = 4,
  localparam int BE_W         = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,

  input  logic              ld_req_valid,
  output logic              ld_req_ready,
  input  logic [ADDR_W-1:0] ld_req_addr,
  output logic              ld_resp_valid,
  output logic [DATA_W-1:0] ld_resp_data,

  input  logic              st_req_valid,
  output logic              st_req_ready,
  input  logic [ADDR_W-1:0] st_req_addr,
  input  logic [DATA_W-1:0] st_req_data,
  input  logic [BE_W-1:0]   st_req_be,
  output logic              st_resp_valid,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [BE_W-1:0]   mem_req_be,

  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,

  output logic              err_unexp_resp
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTST);

  // Tag values stored in the FIFO for each outstanding read.
  localparam logic TAG_IF = 1'b0;
  localparam logic TAG_LD = 1'b1;

  // Which requester owns the memory port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_LD   = 2'd2,
    GNT_ST   = 2'd3
  } grant_e;

  grant_e grant;

  // Tag FIFO storage and bookkeeping.
  logic [MAX_OUTST-1:0] tag_mem;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     tag_cnt;

  logic fifo_empty;
  logic fifo_full;
  logic head_tag;
  logic push;
  logic pop;

  logic rd_eligible;
  logic if_elig;
  logic ld_elig;
  logic st_elig;
  logic promote;

  logic if_hs;
  logic ld_hs;
  logic st_hs;

  logic st_resp_q;
  logic err_q;

  // --------------------------------------------------------------------------
  // FIFO status and eligibility
  // --------------------------------------------------------------------------
  assign fifo_empty = (tag_cnt == '0);
  assign fifo_full  = (tag_cnt == FULL_CNT);
  assign head_tag   = tag_mem[rd_ptr];

  // A response only retires a read when one is actually outstanding; a
  // response against an empty FIFO is dropped and flagged instead.
  assign pop = mem_resp_valid && !fifo_empty;

  // A pop in the same cycle frees a slot, so a read may still issue while
  // the FIFO is full as long as a response is retiring the head.
  assign rd_eligible = !fifo_full || pop;

  assign if_elig = if_req_valid && rd_eligible;
  assign ld_elig = ld_req_valid && rd_eligible;
  assign st_elig = st_req_valid;

  // --------------------------------------------------------------------------
  // Fetch starvation counter and promotion
  // --------------------------------------------------------------------------
`ifdef FALCO_ARB_STARVE_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  // Promotion looks at the registered count, so it applies on the cycle
  // after the count reaches the limit.
  assign promote = (starve_cnt >= STARVE_LIM);

  // Counts consecutive cycles a fetch has been waiting. The count restarts
  // whenever the fetch is accepted or withdraws its request, and saturates
  // at 15 so a long wait cannot wrap back into the unpromoted range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!if_req_valid || if_hs) begin
      starve_cnt <= '0;
    end else if (starve_cnt != 4'hF) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  // Without the counter the limit has no effect; fetch can starve.
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT > 0);
  assign promote             = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Grant selection
  // --------------------------------------------------------------------------
  // Base order is LD > ST > IF; a promoted fetch jumps to the front. Nothing
  // is granted while reset is asserted so that all readies stay low then.
  always_comb begin
    grant = GNT_NONE;
    if (rst_n) begin
      if (promote && if_elig) begin
        grant = GNT_IF;
      end else if (ld_elig) begin
        grant = GNT_LD;
      end else if (st_elig) begin
        grant = GNT_ST;
      end else if (if_elig) begin
        grant = GNT_IF;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Memory request mux and per-requester ready
  // --------------------------------------------------------------------------
  // Only the granted requester sees the memory's ready. Write data and byte
  // enables are driven only for stores and held at zero for reads.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_be    = '0;
    if_req_ready  = 1'b0;
    ld_req_ready  = 1'b0;
    st_req_ready  = 1'b0;
    case (grant)
      GNT_IF: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = if_req_addr;
        if_req_ready  = mem_req_ready;
      end
      GNT_LD: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = ld_req_addr;
        ld_req_ready  = mem_req_ready;
      end
      GNT_ST: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = st_req_addr;
        mem_req_wdata = st_req_data;
        mem_req_be    = st_req_be;
        st_req_ready  = mem_req_ready;
      end
      default: begin
      end
    endcase
  end

  assign if_hs = (grant == GNT_IF) && mem_req_ready;
  assign ld_hs = (grant == GNT_LD) && mem_req_ready;
  assign st_hs = (grant == GNT_ST) && mem_req_ready;
  assign push  = if_hs || ld_hs;

  // --------------------------------------------------------------------------
  // Tag FIFO
  // --------------------------------------------------------------------------
  // Every accepted read records who issued it; responses come back in order
  // and retire the head. Push and pop together leave the count unchanged,
  // including when full: the head is read combinationally before the write
  // lands, so the shared slot is safe to reuse in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_mem <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= ld_hs ? TAG_LD : TAG_IF;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        tag_cnt <= tag_cnt + CNT_W'(1);
      end else if (pop && !push) begin
        tag_cnt <= tag_cnt - CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Response routing
  // --------------------------------------------------------------------------
  // Data is forced to zero when the matching valid is low so that idle
  // outputs stay quiet regardless of what the memory drives.
  assign if_resp_valid = pop && (head_tag == TAG_IF);
  assign ld_resp_valid = pop && (head_tag == TAG_LD);
  assign if_resp_data  = if_resp_valid ? mem_resp_rdata : '0;
  assign ld_resp_data  = ld_resp_valid ? mem_resp_rdata : '0;

  // --------------------------------------------------------------------------
  // Store acknowledge and unexpected-response flag
  // --------------------------------------------------------------------------
  // Stores are posted: the acknowledge is a single registered pulse on the
  // cycle after the store handshake. The error flag is sticky until reset;
  // a reset also discards all outstanding tags, so any response still in
  // flight from before the reset will land here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_resp_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      st_resp_q <= st_hs;
      if (mem_resp_valid && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign st_resp_valid  = st_resp_q;
  assign err_unexp_resp = err_q;

endmodule

// File: tb/tb_falco_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_falco_mem_arbiter
//
// Purpose:
//   Self-checking bench for falco_mem_arbiter. A behavioural reference model
//   (queue of outstanding read owners, an integer wait count and an ordered
//   priority list) predicts every output each cycle. Directed steps cover
//   reset, priority, routing, backpressure, starvation and the unexpected
//   response flag; a randomized phase then exercises mixed traffic.
//   Behaviour follows the FALCO_ARB_STARVE_EN macro in the same way as the
//   design.
// ----------------------------------------------------------------------------
module tb_falco_mem_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int BE_W         = DATA_W / 8;
  localparam int MAX_OUTST    = 4;
  localparam int STARVE_LIMIT = 4;

  logic              clk;
  logic              rst_n;
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_resp_valid;
  logic [DATA_W-1:0] if_resp_data;
  logic              ld_req_valid;
  logic              ld_req_ready;
  logic [ADDR_W-1:0] ld_req_addr;
  logic              ld_resp_valid;
  logic [DATA_W-1:0] ld_resp_data;
  logic              st_req_valid;
  logic              st_req_ready;
  logic [ADDR_W-1:0] st_req_addr;
  logic [DATA_W-1:0] st_req_data;
  logic [BE_W-1:0]   st_req_be;
  logic              st_resp_valid;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [BE_W-1:0]   mem_req_be;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_rdata;
  logic              err_unexp_resp;

  int checks = 0;
  int errors = 0;

  // Reference model state: owners of outstanding reads (0 = IF, 1 = LD),
  // cycles the fetch has waited, and the expected registered outputs.
  bit tag_q[$];
  int starve;
  bit st_resp_exp;
  bit err_exp;

  // Model decision for the current cycle: 0 none, 1 IF, 2 LD, 3 ST.
  int exp_gnt;
  bit exp_pop;
  bit exp_hs;

  // DUT outputs captured in the most recent step, for directed checks.
  logic [2:0]        snap_rdy;
  logic              snap_req_valid;
  logic [ADDR_W-1:0] snap_addr;
  logic              snap_st_resp;
  logic              snap_if_resp;
  logic              snap_ld_resp;
  logic [DATA_W-1:0] snap_if_data;
  logic [DATA_W-1:0] snap_ld_data;
  logic              snap_err;

  falco_mem_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MAX_OUTST   (MAX_OUTST),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_resp_valid (if_resp_valid),
    .if_resp_data  (if_resp_data),
    .ld_req_valid  (ld_req_valid),
    .ld_req_ready  (ld_req_ready),
    .ld_req_addr   (ld_req_addr),
    .ld_resp_valid (ld_resp_valid),
    .ld_resp_data  (ld_resp_data),
    .st_req_valid  (st_req_valid),
    .st_req_ready  (st_req_ready),
    .st_req_addr   (st_req_addr),
    .st_req_data   (st_req_data),
    .st_req_be     (st_req_be),
    .st_resp_valid (st_resp_valid),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_be    (mem_req_be),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_rdata(mem_resp_rdata),
    .err_unexp_resp(err_unexp_resp)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any difference.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Return the model to its post-reset state.
  function automatic void model_reset();
    tag_q.delete();
    starve      = 0;
    st_resp_exp = 1'b0;
    err_exp     = 1'b0;
  endfunction

  // Decide this cycle's grant from the current inputs by walking the
  // priority list and picking the first requester that may go.
  function automatic void model_eval();
    bit rd_ok;
    bit promote;
    bit may_go;
    int order[3];
    exp_pop = rst_n && mem_resp_valid && (tag_q.size() > 0);
    rd_ok   = (tag_q.size() < MAX_OUTST) || exp_pop;
    promote = 1'b0;
`ifdef FALCO_ARB_STARVE_EN
    promote = (starve >= STARVE_LIMIT);
`endif
    if (promote) order = '{1, 2, 3};
    else         order = '{2, 3, 1};
    exp_gnt = 0;
    if (rst_n) begin
      foreach (order[i]) begin
        case (order[i])
          1:       may_go = if_req_valid && rd_ok;
          2:       may_go = ld_req_valid && rd_ok;
          default: may_go = st_req_valid;
        endcase
        if (exp_gnt == 0 && may_go) exp_gnt = order[i];
      end
    end
    exp_hs = (exp_gnt != 0) && mem_req_ready;
  endfunction

  // Advance the model by one clock edge.
  function automatic void model_update();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (mem_resp_valid && tag_q.size() == 0) err_exp = 1'b1;
      if (exp_pop) void'(tag_q.pop_front());
      if (exp_hs && (exp_gnt == 1 || exp_gnt == 2)) tag_q.push_back(exp_gnt == 2);
      st_resp_exp = exp_hs && (exp_gnt == 3);
      if (!if_req_valid || (exp_hs && exp_gnt == 1)) starve = 0;
      else if (starve < 15) starve = starve + 1;
    end
  endfunction

  // Compare every DUT output against the model's prediction for this cycle.
  task automatic checkOutput();
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic [BE_W-1:0]   e_be;
    logic [2:0]        e_rdy;
    bit                head;
    case (exp_gnt)
      1:       e_addr = if_req_addr;
      2:       e_addr = ld_req_addr;
      3:       e_addr = st_req_addr;
      default: e_addr = '0;
    endcase
    e_wdata = (exp_gnt == 3) ? st_req_data : '0;
    e_be    = (exp_gnt == 3) ? st_req_be : '0;
    e_rdy   = {exp_gnt == 1, exp_gnt == 2, exp_gnt == 3} & {3{mem_req_ready}};
    head    = (tag_q.size() > 0) ? tag_q[0] : 1'b0;
    check("mem_req_valid", 64'(mem_req_valid), 64'(exp_gnt != 0));
    check("mem_req_addr", 64'(mem_req_addr), 64'(e_addr));
    check("mem_req_we", 64'(mem_req_we), 64'(exp_gnt == 3));
    check("mem_req_wdata", 64'(mem_req_wdata), 64'(e_wdata));
    check("mem_req_be", 64'(mem_req_be), 64'(e_be));
    check("readies_if_ld_st", 64'({if_req_ready, ld_req_ready, st_req_ready}), 64'(e_rdy));
    check("if_resp_valid", 64'(if_resp_valid), 64'(exp_pop && !head));
    check("if_resp_data", 64'(if_resp_data), 64'((exp_pop && !head) ? mem_resp_rdata : '0));
    check("ld_resp_valid", 64'(ld_resp_valid), 64'(exp_pop && head));
    check("ld_resp_data", 64'(ld_resp_data), 64'((exp_pop && head) ? mem_resp_rdata : '0));
    check("st_resp_valid", 64'(st_resp_valid), 64'(st_resp_exp));
    check("err_unexp_resp", 64'(err_unexp_resp), 64'(err_exp));
  endtask

  // One clock cycle: inputs are already set (just after a falling edge),
  // let them settle, check, clock the model, and return at the next
  // falling edge.
  task automatic applyStimulus();
    if (!rst_n) model_reset();
    #1;
    model_eval();
    checkOutput();
    snap_rdy       = {if_req_ready, ld_req_ready, st_req_ready};
    snap_req_valid = mem_req_valid;
    snap_addr      = mem_req_addr;
    snap_st_resp   = st_resp_valid;
    snap_if_resp   = if_resp_valid;
    snap_ld_resp   = ld_resp_valid;
    snap_if_data   = if_resp_data;
    snap_ld_data   = ld_resp_data;
    snap_err       = err_unexp_resp;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_req_valid   = 1'b0;
    if_req_addr    = '0;
    ld_req_valid   = 1'b0;
    ld_req_addr    = '0;
    st_req_valid   = 1'b0;
    st_req_addr    = '0;
    st_req_data    = '0;
    st_req_be      = '0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
  endtask

  initial begin : main
    int first_if;
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);

    // ---- Reset with every requester valid, then priority order ----
    $display("[TB] reset and priority");
    if_req_valid = 1'b1; if_req_addr = 32'h100;
    ld_req_valid = 1'b1; ld_req_addr = 32'h200;
    st_req_valid = 1'b1; st_req_addr = 32'h300;
    st_req_data  = 32'hCAFE_F00D; st_req_be = 4'hF;
    applyStimulus();
    check("reset_readies", 64'(snap_rdy), 64'(3'b000));
    check("reset_req_valid", 64'(snap_req_valid), 64'(0));
    rst_n = 1'b1;
    applyStimulus();
    check("prio_rdy0_ld", 64'(snap_rdy), 64'(3'b010));
    check("prio_addr0", 64'(snap_addr), 64'h200);
    ld_req_valid = 1'b0;
    applyStimulus();
    check("prio_addr1", 64'(snap_addr), 64'h300);
    st_req_valid = 1'b0;
    applyStimulus();
    check("prio_addr2", 64'(snap_addr), 64'h100);
    check("st_ack_pulse", 64'(snap_st_resp), 64'(1));
    if_req_valid = 1'b0;
    applyStimulus();
    check("st_ack_one_cycle", 64'(snap_st_resp), 64'(0));
    // Drain the two outstanding reads: the load went first.
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1111;
    applyStimulus();
    check("drain_ld_first", 64'({snap_if_resp, snap_ld_resp}), 64'(2'b01));
    mem_resp_rdata = 32'h2222;
    applyStimulus();
    check("drain_if_second", 64'({snap_if_resp, snap_ld_resp}), 64'(2'b10));
    mem_resp_valid = 1'b0;
    applyStimulus();

    // ---- Response routing ----
    $display("[TB] routing");
    do_reset();
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    applyStimulus();
    if_req_valid = 1'b0;
    ld_req_valid = 1'b1; ld_req_addr = 32'h20;
    applyStimulus();
    ld_req_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hAAAA;
    applyStimulus();
    check("route_if_valid", 64'({snap_if_resp, snap_ld_resp}), 64'(2'b10));
    check("route_if_data", 64'(snap_if_data), 64'hAAAA);
    mem_resp_rdata = 32'hBBBB;
    applyStimulus();
    check("route_ld_valid", 64'({snap_if_resp, snap_ld_resp}), 64'(2'b01));
    check("route_ld_data", 64'(snap_ld_data), 64'hBBBB);
    mem_resp_valid = 1'b0;
    applyStimulus();

    // ---- Backpressure on a full tag FIFO ----
    $display("[TB] backpressure");
    do_reset();
    ld_req_valid = 1'b1;
    for (int i = 0; i < MAX_OUTST; i++) begin
      ld_req_addr = 32'h400 + 32'(4 * i);
      applyStimulus();
      check("bp_fill_ld_ready", 64'(snap_rdy), 64'(3'b010));
    end
    ld_req_addr  = 32'h500;
    st_req_valid = 1'b1; st_req_addr = 32'h600;
    st_req_data  = 32'h5A5A_A5A5; st_req_be = 4'h3;
    applyStimulus();
    check("bp_full_only_st", 64'(snap_rdy), 64'(3'b001));
    st_req_valid   = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234;
    applyStimulus();
    check("bp_pop_push_ld", 64'(snap_rdy), 64'(3'b010));
    check("bp_pop_resp", 64'(snap_ld_resp), 64'(1));
    ld_req_valid   = 1'b0;
    mem_resp_valid = 1'b0;
    applyStimulus();

    // ---- Starvation: LD always valid, IF valid from the second cycle ----
    $display("[TB] starvation");
    do_reset();
    first_if = 0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      ld_req_valid   = 1'b1;
      ld_req_addr    = 32'h8000 + 32'(cyc * 4);
      if (cyc == 2) begin
        if_req_valid = 1'b1;
        if_req_addr  = 32'h700;
      end
      mem_resp_valid = (tag_q.size() > 0);
      mem_resp_rdata = $urandom;
      applyStimulus();
      if (snap_rdy[2] && first_if == 0) begin
        first_if     = cyc;
        if_req_valid = 1'b0;
      end
    end
`ifdef FALCO_ARB_STARVE_EN
    check("starve_if_grant_cycle", 64'(first_if), 64'(6));
`else
    check("starve_if_never_granted", 64'(first_if), 64'(0));
`endif
    clear_inputs();
    mem_resp_valid = (tag_q.size() > 0);
    applyStimulus();
    mem_resp_valid = 1'b0;
    applyStimulus();

    // ---- Unexpected response and reset mid-operation ----
    $display("[TB] unexpected response");
    do_reset();
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD;
    applyStimulus();
    check("unexp_no_resp", 64'({snap_if_resp, snap_ld_resp}), 64'(2'b00));
    check("unexp_err_not_yet", 64'(snap_err), 64'(0));
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      check("unexp_err_sticky", 64'(snap_err), 64'(1));
    end
    rst_n = 1'b0;
    applyStimulus();
    check("err_cleared_by_reset", 64'(snap_err), 64'(0));
    rst_n = 1'b1;
    ld_req_valid = 1'b1; ld_req_addr = 32'h900;
    applyStimulus();
    ld_req_valid = 1'b0;
    rst_n = 1'b0;
    applyStimulus();
    rst_n = 1'b1;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hBEEF;
    applyStimulus();
    check("late_resp_dropped", 64'({snap_if_resp, snap_ld_resp}), 64'(2'b00));
    mem_resp_valid = 1'b0;
    applyStimulus();
    check("late_resp_err", 64'(snap_err), 64'(1));

    // ---- Randomized mixed traffic ----
    $display("[TB] random traffic");
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (!if_req_valid) begin
        if_req_valid = ($urandom_range(0, 1) == 1);
        if_req_addr  = $urandom;
      end
      if (!ld_req_valid) begin
        ld_req_valid = ($urandom_range(0, 2) == 0);
        ld_req_addr  = $urandom;
      end
      if (!st_req_valid) begin
        st_req_valid = ($urandom_range(0, 3) == 0);
        st_req_addr  = $urandom;
        st_req_data  = $urandom;
        st_req_be    = 4'($urandom_range(0, 15));
      end
      mem_req_ready  = ($urandom_range(0, 3) != 0);
      mem_resp_valid = (tag_q.size() > 0) && ($urandom_range(0, 2) != 0);
      mem_resp_rdata = $urandom;
      applyStimulus();
      if (exp_hs && exp_gnt == 1) if_req_valid = 1'b0;
      if (exp_hs && exp_gnt == 2) ld_req_valid = 1'b0;
      if (exp_hs && exp_gnt == 3) st_req_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/falco_mem_arbiter.md
# falco_mem_arbiter

Arbitrates the core's three memory requesters (instruction fetch, load, store) onto a single shared memory port. Issues at most one request per cycle and tracks outstanding reads in an in-order tag FIFO. Routes each read response back to the requester that issued it and acknowledges stores. Sits between `core_top`'s instruction/load/store ports and a single-ported memory model or TCM.

## Interface
- `ADDR_W`, 32, request address width
- `DATA_W`, 32, data width; `BE_W = DATA_W/8`
- `MAX_OUTST`, 4, maximum outstanding reads (tag FIFO depth; power of 2, ≥2)
- `STARVE_LIMIT`, 4, cycles an ifetch may wait before promotion (1..15)

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  reset; asynchronous and active-low
- `if_req_valid` in 1, `if_req_ready` out 1, `if_req_addr` in ADDR_W: fetch request
- `if_resp_valid` out 1, `if_resp_data` out DATA_W: fetch response
- `ld_req_valid` in 1, `ld_req_ready` out 1, `ld_req_addr` in ADDR_W: load request
- `ld_resp_valid` out 1, `ld_resp_data` out DATA_W: load response
- `st_req_valid` in 1, `st_req_ready` out 1, `st_req_addr` in ADDR_W, `st_req_data` in DATA_W, `st_req_be` in BE_W: store request
- `st_resp_valid` out 1: store acknowledge
- `mem_req_valid` out 1, `mem_req_ready` in 1, `mem_req_we` out 1, `mem_req_addr` out ADDR_W, `mem_req_wdata` out DATA_W, `mem_req_be` out BE_W: memory request
- `mem_resp_valid` in 1, `mem_resp_rdata` in DATA_W: in-order read data
- `err_unexp_resp` out 1: sticky; set when a response arrives with no read outstanding

## Operation
- **Request handshake.** A request transfers when valid && ready. Requesters hold valid and payload stable until ready.
- **Eligibility.** A read requester (IF, LD) is eligible only when the tag FIFO is not full, or is popped this cycle. The store requester is always eligible.
- **Base priority:** LD > ST > IF.
- **Promotion.** When `starve_cnt >= STARVE_LIMIT`, IF is promoted above LD and ST.
- **Grant.** Exactly one eligible requester is granted. `mem_req_valid` = (granted requester exists).
  - `mem_req_*` mux the granted payload. `mem_req_we` = 1 only for ST.
  - For reads, `mem_req_wdata` and `mem_req_be` are 0.
  - The granted requester's ready = `mem_req_ready`; all other readies = 0.
- **Tag FIFO.** On a read handshake, push tag (0 = IF, 1 = LD).
  - On `mem_resp_valid` with FIFO non-empty, pop the head and assert `if_resp_valid` or `ld_resp_valid` per the head tag. Response data = `mem_resp_rdata`.
- **Store acknowledge.** On a store handshake, `st_resp_valid` pulses for 1 cycle on the following cycle (posted write).
- **Starvation counter.** `starve_cnt` (4 bit) increments, saturating at 15, each cycle `if_req_valid` is high without an IF handshake. It clears on an IF handshake or when `if_req_valid` is low.
- **Unexpected response.** `mem_resp_valid` with the FIFO empty is dropped: no response valid is asserted and `err_unexp_resp` is set. The error clears only on reset.
- **Simultaneous push/pop.** Push and pop in the same cycle leave the count unchanged, including when the FIFO is full.

## Timing
- **Reset values.** FIFO empty, `starve_cnt` = 0, `st_resp_valid` = 0, `err_unexp_resp` = 0. All combinational outputs are 0 when no requester is valid and the FIFO is empty.
- **Reset mid-operation.** Asserting `rst_n` low discards outstanding tags immediately. Responses arriving after reset release flag `err_unexp_resp`.
- **Request path.** Combinational, 0 cycles: request valid → `mem_req_valid`, and `mem_req_ready` → requester ready.
- **Response path.** Combinational, 0 cycles: `mem_resp_valid` → `if_resp_valid`/`ld_resp_valid`.
- **Store acknowledge.** `st_resp_valid` is registered, 1 cycle after the store handshake.
- **Throughput.** One handshake per cycle. Read issue stalls when MAX_OUTST reads are outstanding and no pop occurs that cycle.
- **Promotion decision.** Uses the registered `starve_cnt`, so it takes effect the cycle after the count reaches STARVE_LIMIT.

## Configuration
- `FALCO_ARB_STARVE_EN` defined: IF promotion as described.
- Undefined: `starve_cnt` is not implemented and priority is strict LD > ST > IF; IF can starve indefinitely.

## Test plan
- **Reset and idle.** Assert `rst_n` = 0 with all requests valid → all readies 0 and `mem_req_valid` = 0.
  - Release reset → LD granted first cycle with `mem_req_ready` = 1.
- **Priority.** IF, LD, ST valid together; `mem_req_ready` = 1; addresses 0x100/0x200/0x300.
  - `mem_req_addr` sequence = 0x200, 0x300, 0x100.
  - `st_resp_valid` pulses in the cycle after the 0x300 grant.
- **Routing.** Issue IF@0x10, then LD@0x20; memory returns 0xAAAA then 0xBBBB.
  - `if_resp_data` = 0xAAAA, then `ld_resp_data` = 0xBBBB; no cross-assertion.
- **Backpressure.** Issue 4 reads with no responses (MAX_OUTST = 4) → 5th read ready = 0 while a store is still accepted.
  - Return 1 response and present a new read in the same cycle → 5th read accepted that cycle.
- **Starvation** (macro defined, STARVE_LIMIT = 4). LD continuously valid, IF valid.
  - IF granted on the 6th cycle (count reaches 4 after 4 waits, promotion next cycle).
  - Macro undefined → IF never granted within 50 cycles.
- **Error.** `mem_resp_valid` = 1 with the FIFO empty → no response valid; `err_unexp_resp` = 1 and stays 1 until `rst_n` is asserted.
